// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite write path: response codes,
// master/slave FSM state encodings and data memory depth.
package axi4_lite_pkg;

    localparam int MEM_WORDS = 1024;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_SEND = 2'd1,
        M_RESP = 2'd2
    } mst_state_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_RESP  = 2'd2
    } slv_state_e;

endpackage

// File: rtl/axi4_lite_write_master.sv
// Command-driven AXI4-Lite write master: turns a one-cycle write_start request
// into AW/W handshakes, then waits for the B response.
module axi4_lite_write_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    write_start,
    input  logic [ADDR_WIDTH-1:0]   write_addr,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [3:0]              write_strobe,
    output logic                    write_busy,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [3:0]              wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    mst_state_e              state_q, state_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    busy_q, busy_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [3:0]              strb_q, strb_d;

    // The slave only ever answers OKAY, so the response code carries no decision here.
    logic unused_bresp;
    assign unused_bresp = ^bresp;

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        case (state_q)
            M_IDLE: begin
                if (write_start) begin
                    addr_d    = write_addr;
                    data_d    = write_data;
                    strb_d    = write_strobe;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = M_SEND;
                end
            end
            M_SEND: begin
                if (awvalid_q && awready) awvalid_d = 1'b0;
                if (wvalid_q && wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = M_RESP;
            end
            M_RESP: begin
                if (bvalid) state_d = M_IDLE;
            end
            default: state_d = M_IDLE;
        endcase
        busy_d = (state_d != M_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= M_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            busy_q    <= busy_d;
        end
    end

    // Payload registers only change on acceptance, so they need no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        strb_q <= strb_d;
    end

    assign awaddr     = addr_q;
    assign wdata      = data_q;
    assign wstrb      = strb_q;
    assign awvalid    = awvalid_q;
    assign wvalid     = wvalid_q;
    assign bready     = (state_q == M_RESP);
    assign write_busy = busy_q;

endmodule

// File: rtl/axi4_lite_write_slave.sv
// AXI4-Lite write slave: captures AW and W in any order, issues a single-cycle
// memory write, then returns an OKAY response.
module axi4_lite_write_slave
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [3:0]              wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [3:0]              mem_byte_en
);

    slv_state_e              state_q, state_d;
    logic                    aw_held_q, aw_held_d;
    logic                    w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [3:0]              strb_q, strb_d;

    assign awready = (state_q == S_IDLE) && !aw_held_q;
    assign wready  = (state_q == S_IDLE) && !w_held_q;

    always_comb begin
        state_d   = state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        case (state_q)
            S_IDLE: begin
                if (awvalid && awready) begin
                    aw_held_d = 1'b1;
                    addr_d    = awaddr;
                end
                if (wvalid && wready) begin
                    w_held_d = 1'b1;
                    data_d   = wdata;
                    strb_d   = wstrb;
                end
                if (aw_held_d && w_held_d) state_d = S_WRITE;
            end
            S_WRITE: begin
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                state_d   = S_RESP;
            end
            S_RESP: begin
                if (bready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        strb_q <= strb_d;
    end

    assign mem_write   = (state_q == S_WRITE);
    assign mem_addr    = addr_q;
    assign mem_wdata   = data_q;
    assign mem_byte_en = strb_q;
    assign bvalid      = (state_q == S_RESP);
    assign bresp       = RESP_OKAY;

endmodule

// File: rtl/data_mem.sv
// 1024 x 32 byte-lane-writable data memory with a combinational read port;
// word index is addr[11:2], so higher addresses alias.
module data_mem
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [3:0]              byte_en,
    input  logic [31:0]             wdata,
    input  logic [11:0]             rd_addr,
    output logic [31:0]             rd_data
);

    logic [31:0] mem_q [MEM_WORDS];
    logic [31:0] wr_word_d;
    logic [9:0]  wr_idx;

    // Sub-word offset and aliased upper address bits deliberately select nothing.
    logic unused_addr;
    assign unused_addr = ^{addr[ADDR_WIDTH-1:12], addr[1:0], rd_addr[1:0]};

    assign wr_idx = addr[11:2];

    always_comb begin
        wr_word_d = mem_q[wr_idx];
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) wr_word_d[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[wr_idx] <= wr_word_d;
        end
    end

    assign rd_data = mem_q[rd_addr[11:2]];

endmodule

// File: rtl/axi4_lite_write_path.sv
// AXI4-Lite write path top: write master, write slave and data memory joined
// over one internal AW/W/B channel set.
module axi4_lite_write_path
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    write_start,
    input  logic [ADDR_WIDTH-1:0]   write_addr,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [3:0]              write_strobe,
    output logic                    write_busy,
    input  logic [11:0]             rd_addr,
    output logic [31:0]             rd_data
);

    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid, awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            wstrb;
    logic                  wvalid, wready;
    logic [1:0]            bresp;
    logic                  bvalid, bready;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_byte_en;

    axi4_lite_write_master #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_master (
        .clk          (clk),
        .rst          (rst),
        .write_start  (write_start),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_strobe (write_strobe),
        .write_busy   (write_busy),
        .awaddr       (awaddr),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wvalid       (wvalid),
        .wready       (wready),
        .bresp        (bresp),
        .bvalid       (bvalid),
        .bready       (bready)
    );

    axi4_lite_write_slave #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_slave (
        .clk          (clk),
        .rst          (rst),
        .awaddr       (awaddr),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wvalid       (wvalid),
        .wready       (wready),
        .bresp        (bresp),
        .bvalid       (bvalid),
        .bready       (bready),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_byte_en  (mem_byte_en)
    );

    data_mem #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .clk      (clk),
        .rst      (rst),
        .we       (mem_write),
        .addr     (mem_addr),
        .byte_en  (mem_byte_en),
        .wdata    (mem_wdata),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

endmodule

// File: tb/tb_axi4_lite_write_path.sv
// Scoreboard bench for axi4_lite_write_path: a stimulus process issues writes
// and queues expected memory words; a monitor checks each completed write.
module tb_axi4_lite_write_path;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_start;
    logic [31:0] write_addr;
    logic [31:0] write_data;
    logic [3:0]  write_strobe;
    logic        write_busy;
    logic [11:0] rd_addr;
    logic [31:0] rd_data;

    always #5 clk = ~clk;

    axi4_lite_write_path dut (
        .clk          (clk),
        .rst          (rst),
        .write_start  (write_start),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_strobe (write_strobe),
        .write_busy   (write_busy),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
    );

    typedef struct {
        int unsigned idx;
        logic [31:0] word;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [1024];
    int          errors = 0;
    int          checks = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a write replaces the enabled byte lanes of word addr[11:2].
    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input bit poke);
        int unsigned idx;
        logic [31:0] w;
        int n;
        @(negedge clk);
        idx = a[11:2];
        w = model[idx];
        for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        model[idx] = w;
        sb_q.push_back('{idx, w});
        write_addr   = a;
        write_data   = d;
        write_strobe = s;
        write_start  = 1'b1;
        @(negedge clk);
        write_start = 1'b0;
        if (poke) begin
            @(negedge clk);
            write_addr   = a + 32'd4;
            write_data   = ~d;
            write_strobe = 4'hF;
            write_start  = 1'b1;
            @(negedge clk);
            write_start = 1'b0;
        end
        n = 0;
        while (write_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", n);
        end
    endtask

    task automatic monitor();
        bit prev = 1'b0;
        int hi = 0;
        int mw = 0;
        exp_t e;
        int unsigned o;
        forever begin
            @(negedge clk);
            if (dut.bvalid) check32("bresp", {30'd0, dut.bresp}, 32'd0);
            if (write_busy && !prev) begin
                hi = 0;
                mw = 0;
            end
            if (write_busy) hi++;
            if (dut.mem_write) mw++;
            if (!write_busy && prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got busy fall, required none");
                end else begin
                    e = sb_q.pop_front();
                    rd_addr = {e.idx[9:0], 2'b00};
                    #1;
                    check32("written_word", rd_data, e.word);
                    check32("busy_cycles", hi, 32'd3);
                    check32("mem_write_pulses", mw, 32'd1);
                    o = $urandom_range(0, 1023);
                    rd_addr = {o[9:0], 2'b00};
                    #1;
                    check32("other_word", rd_data, model[o]);
                end
            end
            prev = write_busy;
        end
    endtask

    initial begin
        int unsigned ra;
        rst          = 1'b1;
        write_start  = 1'b0;
        write_addr   = '0;
        write_data   = '0;
        write_strobe = '0;
        rd_addr      = '0;
        for (int i = 0; i < 1024; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check32("reset_busy", {31'd0, write_busy}, 32'd0);
        check32("reset_awvalid", {31'd0, dut.awvalid}, 32'd0);
        check32("reset_wvalid", {31'd0, dut.wvalid}, 32'd0);
        check32("reset_bvalid", {31'd0, dut.bvalid}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            ra = $urandom_range(0, 4095);
            rd_addr = ra[11:0];
            #1;
            check32("reset_mem", rd_data, 32'd0);
        end

        fork
            monitor();
            begin
                do_write(32'h0000_0004, 32'hDEAD_BEEF, 4'b1111, 1'b0);
                do_write(32'h0000_0008, 32'h1234_5678, 4'b1010, 1'b0);
                do_write(32'h0000_0008, 32'hFFFF_FFFF, 4'b0000, 1'b0);
                do_write(32'h0000_0010, 32'hA5A5_5A5A, 4'b1111, 1'b1);
                for (int k = 0; k < 40; k++) begin
                    logic [31:0] a;
                    a = $urandom();
                    if (k % 3 == 0) a = {20'($urandom()), 12'($urandom_range(0, 63))};
                    do_write(a, $urandom(), 4'($urandom()), ($urandom_range(0, 3) == 0));
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
        join_any
        repeat (4) @(negedge clk);
        disable fork;
        check32("scoreboard_drained", sb_q.size(), 32'd0);

        // Abort a write to 0x10 with reset during its handshake cycle.
        @(negedge clk);
        write_addr   = 32'h0000_0010;
        write_data   = 32'hCAFE_F00D;
        write_strobe = 4'hF;
        write_start  = 1'b1;
        @(negedge clk);
        write_start = 1'b0;
        rst = 1'b1;
        #1;
        check32("abort_busy", {31'd0, write_busy}, 32'd0);
        check32("abort_awvalid", {31'd0, dut.awvalid}, 32'd0);
        check32("abort_wvalid", {31'd0, dut.wvalid}, 32'd0);
        check32("abort_mem_write", {31'd0, dut.mem_write}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check32("abort_busy_after", {31'd0, write_busy}, 32'd0);
        rd_addr = 12'h010;
        #1;
        check32("abort_word_0x10", rd_data, 32'd0);
        rd_addr = 12'h004;
        #1;
        check32("reset_cleared_0x04", rd_data, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
